// File: rtl/pp_pipeline_accel_pkg.sv
// Shared constants and helpers for the pp_pipeline_accel fixed-point stages.
package pp_pipeline_accel_pkg;

    localparam int DEF_FRAC_BITS  = 20;
    localparam int DEF_DOUT_WIDTH = 16;

    function automatic logic [63:0] round_const(input int frac_bits);
        return 64'd1 << (frac_bits - 1);
    endfunction

    function automatic logic [63:0] max_out(input int dout_width);
        return (64'd1 << dout_width) - 64'd1;
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_skid_buf.sv
// Two-entry registered valid/ready buffer; head register drives the output directly.
module pp_pipeline_accel_skid_buf
    import pp_pipeline_accel_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             head_vld_r;
    logic             tail_vld_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic             push_s;
    logic             pop_s;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_ready  = !tail_vld_r || out_ready;
    assign out_valid = head_vld_r;
    assign out_data  = head_r;
    assign count     = {tail_vld_r, head_vld_r & ~tail_vld_r};
    assign push_s    = in_valid && in_ready;
    assign pop_s     = head_vld_r && out_ready;

    // Entry storage and occupancy update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
            head_r     <= {WIDTH{1'b0}};
            tail_r     <= {WIDTH{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (!head_vld_r) begin
                        head_r     <= in_data;
                        head_vld_r <= 1'b1;
                    end else begin
                        tail_r     <= in_data;
                        tail_vld_r <= 1'b1;
                    end
                end
                2'b01: begin
                    head_r     <= tail_r;
                    head_vld_r <= tail_vld_r;
                    tail_vld_r <= 1'b0;
                end
                2'b11: begin
                    if (tail_vld_r) begin
                        head_r <= tail_r;
                        tail_r <= in_data;
                    end else begin
                        head_r <= in_data;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/pp_pipeline_accel_prod_round_sat.sv
// Round-half-up and clamp of multiplier products, with skid-buffered output and clamp counter.
module pp_pipeline_accel_prod_round_sat
    import pp_pipeline_accel_pkg::*;
#(
    parameter int DIN_WIDTH  = 52,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DIN_WIDTH-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DOUT_WIDTH-1:0] m_data,
    output logic                  m_sat,
    input  logic                  clear_count,
    output logic [CNT_WIDTH-1:0]  sat_count
);

    localparam int                 RW    = DIN_WIDTH + 1 - FRAC_BITS;
    localparam logic [DIN_WIDTH:0] RND_C = (DIN_WIDTH + 1)'(round_const(FRAC_BITS));
    localparam logic [RW-1:0]      MAX_R = RW'(max_out(DOUT_WIDTH));

    logic                  rnd_valid_r;
    logic [RW-1:0]         rnd_data_r;
    logic                  sat_valid_r;
    logic [DOUT_WIDTH-1:0] sat_data_r;
    logic                  sat_flag_r;
    logic                  ready_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    logic [DIN_WIDTH:0]    sum_s;
    logic [RW-1:0]         rnd_next_s;
    logic                  over_s;
    logic [DOUT_WIDTH-1:0] clamp_s;
    logic                  skid_in_ready_s;
    logic [1:0]            skid_count_s;
    logic [1:0]            skid_count_n_s;
    logic                  sat_adv_s;
    logic                  rnd_adv_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  rnd_valid_n_s;
    logic                  sat_valid_n_s;
    logic                  ready_n_s;
    logic                  inc_s;

    // Carry out of the rounding add is kept so near-full-scale products still clamp.
    assign sum_s      = {1'b0, s_data} + RND_C;
    assign rnd_next_s = RW'(sum_s >> FRAC_BITS);
    assign over_s     = rnd_data_r > MAX_R;
    assign clamp_s    = over_s ? {DOUT_WIDTH{1'b1}} : rnd_data_r[DOUT_WIDTH-1:0];

    assign sat_adv_s = !sat_valid_r || skid_in_ready_s;
    assign rnd_adv_s = !rnd_valid_r || sat_adv_s;
    assign accept_s  = s_valid && ready_r;
    assign push_s    = sat_valid_r && skid_in_ready_s;
    assign pop_s     = m_valid && m_ready;
    assign inc_s     = pop_s && m_sat;
    assign s_ready   = ready_r;
    assign sat_count = cnt_r;

    // Next-cycle occupancy; ready only drops when every slot ahead of the input will be taken.
    always_comb begin
        rnd_valid_n_s  = rnd_valid_r;
        sat_valid_n_s  = sat_valid_r;
        skid_count_n_s = skid_count_s;
        if (rnd_adv_s) begin
            rnd_valid_n_s = accept_s;
        end else begin
            rnd_valid_n_s = rnd_valid_r;
        end
        if (sat_adv_s) begin
            sat_valid_n_s = rnd_valid_r;
        end else begin
            sat_valid_n_s = sat_valid_r;
        end
        case ({push_s, pop_s})
            2'b10:   skid_count_n_s = skid_count_s + 2'd1;
            2'b01:   skid_count_n_s = skid_count_s - 2'd1;
            default: skid_count_n_s = skid_count_s;
        endcase
        ready_n_s = !(rnd_valid_n_s && sat_valid_n_s && (skid_count_n_s == 2'd2));
    end

    // Round and saturate pipeline registers plus the registered input ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_valid_r <= 1'b0;
            rnd_data_r  <= {RW{1'b0}};
            sat_valid_r <= 1'b0;
            sat_data_r  <= {DOUT_WIDTH{1'b0}};
            sat_flag_r  <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            rnd_valid_r <= rnd_valid_n_s;
            sat_valid_r <= sat_valid_n_s;
            ready_r     <= ready_n_s;
            if (rnd_adv_s && accept_s) begin
                rnd_data_r <= rnd_next_s;
            end
            if (sat_adv_s && rnd_valid_r) begin
                sat_data_r <= clamp_s;
                sat_flag_r <= over_s;
            end
        end
    end

    // Clamp counter; a clear coinciding with a clamp leaves a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (clear_count) begin
            cnt_r <= inc_s ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : {CNT_WIDTH{1'b0}};
        end else if (inc_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    pp_pipeline_accel_skid_buf #(
        .WIDTH (DOUT_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sat_valid_r),
        .in_ready  (skid_in_ready_s),
        .in_data   ({sat_flag_r, sat_data_r}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  ({m_sat, m_data}),
        .count     (skid_count_s)
    );

endmodule

// File: tb/tb_pp_pipeline_accel_prod_round_sat.sv
// Scoreboard bench for the round/saturate stage: vector table plus multi-cycle sequences.
module tb_pp_pipeline_accel_prod_round_sat;

    typedef struct {
        logic [51:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready, s_ready4;
    logic [51:0] s_data;
    logic        m_valid, m_valid4;
    logic        m_ready;
    logic [15:0] m_data, m_data4;
    logic        m_sat, m_sat4;
    logic        clear_count;
    logic [31:0] sat_count;
    logic [3:0]  sat_count4;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_cur;
    vec_t        vecs[9];
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    int          out_cnt = 0;
    int          consec = 0;
    bit          prev_xfer = 0;
    bit          prev_stall = 0;
    logic [16:0] prev_out;
    bit          bp_phase = 0;
    bit          done = 0;
    logic [5:0]  pat = 6'b101001;

    always #5 clk = ~clk;

    pp_pipeline_accel_prod_round_sat dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .clear_count(clear_count), .sat_count(sat_count)
    );

    pp_pipeline_accel_prod_round_sat #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_sat(m_sat4),
        .clear_count(clear_count), .sat_count(sat_count4)
    );

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [16:0] model(input logic [51:0] d);
        logic [52:0] s;
        logic [32:0] r;
        s = {1'b0, d} + 53'h80000;
        r = s[52:20];
        if (r > 33'hFFFF) return {1'b1, 16'hFFFF};
        else return {1'b0, r[15:0]};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer, track counters.
    always @(negedge clk) begin
        bit          xfer;
        bit          inc;
        logic [16:0] e;
        xfer = 1'b0;
        inc  = 1'b0;
        if (reset) begin
            exp_q.delete();
            cnt32 = 32'd0;
            cnt4 = 4'd0;
            prev_stall = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            chk(sat_count == cnt32, "sat_count", 64'(sat_count), 64'(cnt32));
            chk(sat_count4 == cnt4, "sat_count4", 64'(sat_count4), 64'(cnt4));
            if (prev_stall)
                chk(m_valid && ({m_sat, m_data} == prev_out), "stall_stable",
                    64'({m_valid, m_sat, m_data}), 64'({1'b1, prev_out}));
            if (bp_phase && !s_ready)
                chk(m_valid, "ready_low_only_when_full", 64'(m_valid), 64'd1);
            if (m_valid && m_ready) begin
                xfer = 1'b1;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "stale_output", 64'({m_sat, m_data}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({m_sat, m_data} == e, "out_data", 64'({m_sat, m_data}), 64'(e));
                    chk(m_valid4 && ({m_sat4, m_data4} == e), "out_data4", 64'({m_valid4, m_sat4, m_data4}), 64'({1'b1, e}));
                    inc = e[16];
                end
                out_cnt++;
                if (prev_xfer) consec++;
            end else if (m_valid && exp_q.size() == 0) begin
                chk(1'b0, "stale_valid", 64'({m_sat, m_data}), 64'd0);
            end
            if (s_valid && s_ready) begin
                chk(s_ready4, "s_ready4", 64'(s_ready4), 64'd1);
                exp_q.push_back(exp_cur);
            end
            if (clear_count) begin
                cnt32 = inc ? 32'd1 : 32'd0;
                cnt4 = inc ? 4'd1 : 4'd0;
            end else if (inc) begin
                if (cnt32 != 32'hFFFF_FFFF) cnt32 = cnt32 + 32'd1;
                if (cnt4 != 4'hF) cnt4 = cnt4 + 4'd1;
            end
            prev_stall = m_valid && !m_ready;
            prev_out = {m_sat, m_data};
            prev_xfer = xfer;
        end
    end

    task automatic send(input logic [51:0] d, input logic [16:0] e, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        s_valid = 1'b1;
        s_data = d;
        exp_cur = e;
        while (!acc && waited < 100) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        s_valid = 1'b0;
        chk(acc, "send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w;
        int base_cnt;
        int base_consec;
        bit all_ready;
        vecs[0] = '{52'h380000,          16'd4,      1'b0};
        vecs[1] = '{52'h37FFFF,          16'd3,      1'b0};
        vecs[2] = '{52'h7FFFF,           16'd0,      1'b0};
        vecs[3] = '{52'h80000,           16'd1,      1'b0};
        vecs[4] = '{52'hFFFF00000,       16'hFFFF,   1'b0};
        vecs[5] = '{52'hFFFF7FFFF,       16'hFFFF,   1'b0};
        vecs[6] = '{52'h1000000000,      16'hFFFF,   1'b1};
        vecs[7] = '{52'hF_FFFF_FFFF_FFFF, 16'hFFFF,  1'b1};
        vecs[8] = '{52'hFFFF80000,       16'hFFFF,   1'b1};

        reset = 1'b0; s_valid = 1'b0; s_data = 52'd0; m_ready = 1'b0;
        clear_count = 1'b0; exp_cur = 17'd0;
        #2 reset = 1'b1;
        #1;
        chk(m_valid == 1'b0, "rst_m_valid", 64'(m_valid), 64'd0);
        chk(s_ready == 1'b0, "rst_s_ready", 64'(s_ready), 64'd0);
        chk({m_sat, m_data} == 17'd0, "rst_m_data", 64'({m_sat, m_data}), 64'd0);
        chk(sat_count == 32'd0, "rst_sat_count", 64'(sat_count), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk(s_ready == 1'b0, "s_ready_before_edge", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        chk(s_ready == 1'b1, "s_ready_after_edge", 64'(s_ready), 64'd1);
        m_ready = 1'b1;

        // Latency of the first sample: visible after the second edge past acceptance.
        s_valid = 1'b1; s_data = vecs[0].din; exp_cur = {vecs[0].sat, vecs[0].dout};
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk); chk(m_valid == 1'b0, "latency_n0", 64'(m_valid), 64'd0);
        @(negedge clk); chk(m_valid == 1'b0, "latency_n1", 64'(m_valid), 64'd0);
        @(negedge clk); chk(m_valid == 1'b1, "latency_n2", 64'(m_valid), 64'd1);
        @(posedge clk); #1;

        for (int i = 1; i < 9; i++) send(vecs[i].din, {vecs[i].sat, vecs[i].dout}, w);
        drain();

        // Backpressure with a repeating ready pattern.
        base_cnt = out_cnt;
        bp_phase = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) send(52'(k) << 20, {1'b0, 16'(k)}, w);
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 400 && (!done || exp_q.size() != 0); i++) begin
                    m_ready = pat[i % 6];
                    @(posedge clk); #1;
                end
            end
        join
        bp_phase = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk(out_cnt - base_cnt == 16, "bp_count", 64'(out_cnt - base_cnt), 64'd16);
        chk(exp_q.size() == 0, "bp_drained", 64'(exp_q.size()), 64'd0);

        // Full throughput.
        base_cnt = out_cnt;
        base_consec = consec;
        all_ready = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            s_data = 52'(k * 3 + 1) << 19;
            exp_cur = model(s_data);
            if (!s_ready) all_ready = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        drain();
        chk(all_ready, "tput_s_ready", 64'(all_ready), 64'd1);
        chk(out_cnt - base_cnt == 32, "tput_count", 64'(out_cnt - base_cnt), 64'd32);
        chk(consec - base_consec == 31, "tput_consec", 64'(consec - base_consec), 64'd31);

        // Reset mid-stream with a nonzero counter and three samples in flight.
        send(52'h1000000000, {1'b1, 16'hFFFF}, w);
        drain();
        m_ready = 1'b0;
        for (int k = 1; k < 4; k++) send(52'(k) << 20, {1'b0, 16'(k)}, w);
        reset = 1'b1;
        #1;
        chk(m_valid == 1'b0, "midrst_m_valid", 64'(m_valid), 64'd0);
        chk(s_ready == 1'b0, "midrst_s_ready", 64'(s_ready), 64'd0);
        chk(sat_count == 32'd0, "midrst_sat_count", 64'(sat_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk(s_ready == 1'b0, "midrst_ready_hold", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        chk(s_ready == 1'b1, "midrst_ready_rise", 64'(s_ready), 64'd1);
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk(m_valid == 1'b0, "midrst_no_stale", 64'(m_valid), 64'd0);

        // Clear coinciding with a clamped output transfer.
        send(52'h1000000000, {1'b1, 16'hFFFF}, w);
        send(52'h1000000000, {1'b1, 16'hFFFF}, w);
        drain();
        m_ready = 1'b0;
        send(52'hF_FFFF_FFFF_FFFF, {1'b1, 16'hFFFF}, w);
        for (int k = 0; k < 20 && !m_valid; k++) begin @(posedge clk); #1; end
        chk(m_valid == 1'b1, "clr_wait_valid", 64'(m_valid), 64'd1);
        clear_count = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        chk(sat_count == 32'd1, "clr_with_inc", 64'(sat_count), 64'd1);
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        chk(sat_count == 32'd0, "clr_alone", 64'(sat_count), 64'd0);

        // Saturating counter at narrow width.
        for (int k = 0; k < 17; k++) send(52'h1000000000 + 52'(k), {1'b1, 16'hFFFF}, w);
        drain();
        @(posedge clk); #1;
        chk(sat_count4 == 4'hF, "cnt4_saturates", 64'(sat_count4), 64'hF);
        chk(sat_count == 32'd17, "cnt32_17", 64'(sat_count), 64'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=%0d", 200000, 0);
        $fatal(1);
    end

endmodule
